// File: rtl/mul_rs_pkg.sv
// Shared types for the multiply reservation station: ALU op and CDB packet
// definitions, the ROB tag type and the station entry layout.
package mul_rs_pkg;

  localparam int MUL_RS_TAG_W = 4;

  typedef logic [MUL_RS_TAG_W-1:0] rob_tag_t;

  // Bit 0 of every multiply op selects the high half of the product.
  typedef enum logic [3:0] {
    ALU_MUL    = 4'h0,
    ALU_MULH   = 4'h1,
    ALU_MULHSU = 4'h3,
    ALU_MULHU  = 4'h5
  } ALU_op_t;

  typedef struct packed {
    rob_tag_t    dest_ROB_entry;
    logic [31:0] result;
  } CDB_packet_t;

  typedef struct packed {
    logic        valid;
    rob_tag_t    rob;
    ALU_op_t     op;
    logic [31:0] a_val;
    logic        a_rdy;
    rob_tag_t    a_tag;
    logic [31:0] b_val;
    logic        b_rdy;
    rob_tag_t    b_tag;
  } mul_rs_entry_t;

  function automatic logic [3:0] popcount8(input logic [7:0] v);
    logic [3:0] n;
    n = '0;
    for (int i = 0; i < 8; i++) n = n + 4'(v[i]);
    return n;
  endfunction

endpackage

// File: rtl/mul_rs_select.sv
// Issue picker for mul_rs: one-hot grant among ready entries.
// MUL_RS_AGE_EN selects oldest-first via an age matrix; otherwise lowest index wins.
module mul_rs_select
  import mul_rs_pkg::*;
#(
  parameter int DEPTH = 4
) (
  input  logic [DEPTH-1:0]            ready,
`ifdef MUL_RS_AGE_EN
  // older[j][i] = 1 means entry j was dispatched before entry i
  input  logic [DEPTH-1:0][DEPTH-1:0] older,
`endif
  output logic [DEPTH-1:0]            grant,
  output logic                        any_ready
);

`ifdef MUL_RS_AGE_EN
  always_comb begin
    grant = '0;
    for (int i = 0; i < DEPTH; i++) begin
      grant[i] = ready[i];
      for (int j = 0; j < DEPTH; j++) begin
        if (j != i && ready[j] && older[j][i]) grant[i] = 1'b0;
      end
    end
  end
`else
  logic found;

  always_comb begin
    grant = '0;
    found = 1'b0;
    for (int i = 0; i < DEPTH; i++) begin
      if (ready[i] && !found) begin
        grant[i] = 1'b1;
        found    = 1'b1;
      end
    end
  end
`endif

  assign any_ready = |ready;

endmodule

// File: rtl/mul_rs.sv
// Reservation station for the integer multiply unit: dispatch, CDB wakeup,
// single issue per cycle, flush. MUL_RS_AGE_EN enables oldest-first issue.
module mul_rs
  import mul_rs_pkg::*;
#(
  parameter int DEPTH = 4,
  parameter int TAG_W = MUL_RS_TAG_W
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     flush,
  input  logic                     disp_valid,
  output logic                     disp_ready,
  input  logic [TAG_W-1:0]         disp_rob_entry,
  input  ALU_op_t                  disp_op,
  input  logic [31:0]              disp_a_val,
  input  logic [31:0]              disp_b_val,
  input  logic                     disp_a_rdy,
  input  logic                     disp_b_rdy,
  input  logic [TAG_W-1:0]         disp_a_tag,
  input  logic [TAG_W-1:0]         disp_b_tag,
  input  logic                     cdb_valid,
  input  CDB_packet_t              cdb,
  input  logic                     fu_ready,
  output logic                     fu_valid,
  output logic [31:0]              fu_a,
  output logic [31:0]              fu_b,
  output logic [TAG_W-1:0]         fu_rob_entry,
  output ALU_op_t                  fu_op,
  output logic [$clog2(DEPTH):0]   occupancy
);

  localparam int OCC_W = $clog2(DEPTH) + 1;

  mul_rs_entry_t    entries_q [DEPTH];
  mul_rs_entry_t    entries_d [DEPTH];
  mul_rs_entry_t    new_entry;
  logic [DEPTH-1:0] valid_vec;
  logic [DEPTH-1:0] ready_vec;
  logic [DEPTH-1:0] alloc;
  logic [DEPTH-1:0] grant;
  logic             alloc_found;
  logic             any_ready;
  logic             dispatch;
  logic             issue;
  logic             disp_a_hit;
  logic             disp_b_hit;
  logic [3:0]       op_bits;

  // NOTE: every variable driven in an always_comb gets a default first,
  // so no path through the block can leave it holding and infer a latch.
  always_comb begin
    valid_vec = '0;
    ready_vec = '0;
    for (int i = 0; i < DEPTH; i++) begin
      valid_vec[i] = entries_q[i].valid;
      ready_vec[i] = entries_q[i].valid & entries_q[i].a_rdy & entries_q[i].b_rdy;
    end
  end

  assign occupancy  = OCC_W'(popcount8(8'(valid_vec)));
  assign disp_ready = (occupancy < OCC_W'(DEPTH));
  assign dispatch   = disp_valid & disp_ready & ~flush;
  assign issue      = any_ready & fu_ready & ~flush;
  assign fu_valid   = issue;

  always_comb begin
    alloc       = '0;
    alloc_found = 1'b0;
    for (int i = 0; i < DEPTH; i++) begin
      if (!valid_vec[i] && !alloc_found) begin
        alloc[i]    = 1'b1;
        alloc_found = 1'b1;
      end
    end
  end

  // An operand whose producer broadcasts in the dispatch cycle is captured
  // here, otherwise no later broadcast would ever wake it.
  assign disp_a_hit = cdb_valid && (cdb.dest_ROB_entry == rob_tag_t'(disp_a_tag));
  assign disp_b_hit = cdb_valid && (cdb.dest_ROB_entry == rob_tag_t'(disp_b_tag));

  always_comb begin
    new_entry.valid = 1'b1;
    new_entry.rob   = rob_tag_t'(disp_rob_entry);
    new_entry.op    = disp_op;
    new_entry.a_rdy = disp_a_rdy | disp_a_hit;
    new_entry.a_val = disp_a_rdy ? disp_a_val : cdb.result;
    new_entry.a_tag = rob_tag_t'(disp_a_tag);
    new_entry.b_rdy = disp_b_rdy | disp_b_hit;
    new_entry.b_val = disp_b_rdy ? disp_b_val : cdb.result;
    new_entry.b_tag = rob_tag_t'(disp_b_tag);
  end

  always_comb begin
    for (int i = 0; i < DEPTH; i++) begin
      entries_d[i] = entries_q[i];
      if (issue && grant[i]) entries_d[i].valid = 1'b0;
      if (cdb_valid && entries_q[i].valid) begin
        if (!entries_q[i].a_rdy && entries_q[i].a_tag == cdb.dest_ROB_entry) begin
          entries_d[i].a_val = cdb.result;
          entries_d[i].a_rdy = 1'b1;
        end
        if (!entries_q[i].b_rdy && entries_q[i].b_tag == cdb.dest_ROB_entry) begin
          entries_d[i].b_val = cdb.result;
          entries_d[i].b_rdy = 1'b1;
        end
      end
      if (dispatch && alloc[i]) entries_d[i] = new_entry;
      if (flush) entries_d[i].valid = 1'b0;
    end
  end

  // NOTE: the entries are plain flops, so the whole entry is cleared on
  // reset; the issue mux then shows zeros rather than stale payload.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < DEPTH; i++) entries_q[i] <= '0;
    end else begin
      // NOTE: state updates use non-blocking assignment so every flop
      // samples the pre-edge values regardless of statement order.
      entries_q <= entries_d;
    end
  end

`ifdef MUL_RS_AGE_EN
  logic [DEPTH-1:0][DEPTH-1:0] older_q;
  logic [DEPTH-1:0][DEPTH-1:0] older_d;

  always_comb begin
    older_d = older_q;
    for (int s = 0; s < DEPTH; s++) begin
      if (issue && grant[s]) begin
        for (int j = 0; j < DEPTH; j++) begin
          older_d[s][j] = 1'b0;
          older_d[j][s] = 1'b0;
        end
      end
    end
    // The newcomer is younger than every entry that stays valid.
    for (int k = 0; k < DEPTH; k++) begin
      if (dispatch && alloc[k]) begin
        for (int j = 0; j < DEPTH; j++) begin
          older_d[k][j] = 1'b0;
          older_d[j][k] = (j != k) && valid_vec[j] && !(issue && grant[j]);
        end
      end
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset)      older_q <= '0;
    else if (flush) older_q <= '0;
    else            older_q <= older_d;
  end
`endif

  mul_rs_select #(.DEPTH(DEPTH)) u_select (
    .ready     (ready_vec),
`ifdef MUL_RS_AGE_EN
    .older     (older_q),
`endif
    .grant     (grant),
    .any_ready (any_ready)
  );

  always_comb begin
    fu_a         = '0;
    fu_b         = '0;
    fu_rob_entry = '0;
    op_bits      = '0;
    for (int i = 0; i < DEPTH; i++) begin
      if (grant[i]) begin
        fu_a         = fu_a | entries_q[i].a_val;
        fu_b         = fu_b | entries_q[i].b_val;
        fu_rob_entry = fu_rob_entry | TAG_W'(entries_q[i].rob);
        op_bits      = op_bits | entries_q[i].op;
      end
    end
  end

  assign fu_op = ALU_op_t'(op_bits);

endmodule

// File: tb/tb_mul_rs.sv
// Scoreboard bench for mul_rs: directed dispatch/wakeup/backpressure/ordering/
// flush/reset vectors; a negedge monitor pops expected issues and compares.
module tb_mul_rs;
  import mul_rs_pkg::*;

  localparam int DEPTH = 4;
  localparam int TAG_W = 4;

  logic              clk;
  logic              reset;
  logic              flush;
  logic              disp_valid;
  logic              disp_ready;
  logic [TAG_W-1:0]  disp_rob_entry;
  ALU_op_t           disp_op;
  logic [31:0]       disp_a_val;
  logic [31:0]       disp_b_val;
  logic              disp_a_rdy;
  logic              disp_b_rdy;
  logic [TAG_W-1:0]  disp_a_tag;
  logic [TAG_W-1:0]  disp_b_tag;
  logic              cdb_valid;
  CDB_packet_t       cdb;
  logic              fu_ready;
  logic              fu_valid;
  logic [31:0]       fu_a;
  logic [31:0]       fu_b;
  logic [TAG_W-1:0]  fu_rob_entry;
  ALU_op_t           fu_op;
  logic [2:0]        occupancy;

  typedef struct {
    logic [3:0]  rob;
    ALU_op_t     op;
    logic [31:0] a;
    logic [31:0] b;
  } exp_t;

  exp_t sb_q[$];
  exp_t mon_e;
  int   errors = 0;
  int   checks = 0;

  mul_rs #(.DEPTH(DEPTH), .TAG_W(TAG_W)) dut (
    .clk            (clk),
    .reset          (reset),
    .flush          (flush),
    .disp_valid     (disp_valid),
    .disp_ready     (disp_ready),
    .disp_rob_entry (disp_rob_entry),
    .disp_op        (disp_op),
    .disp_a_val     (disp_a_val),
    .disp_b_val     (disp_b_val),
    .disp_a_rdy     (disp_a_rdy),
    .disp_b_rdy     (disp_b_rdy),
    .disp_a_tag     (disp_a_tag),
    .disp_b_tag     (disp_b_tag),
    .cdb_valid      (cdb_valid),
    .cdb            (cdb),
    .fu_ready       (fu_ready),
    .fu_valid       (fu_valid),
    .fu_a           (fu_a),
    .fu_b           (fu_b),
    .fu_rob_entry   (fu_rob_entry),
    .fu_op          (fu_op),
    .occupancy      (occupancy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic cycle();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic [3:0] rob, input ALU_op_t op,
                       input logic [31:0] a, input logic ar, input logic [3:0] at,
                       input logic [31:0] b, input logic br, input logic [3:0] bt);
    disp_valid     = 1'b1;
    disp_rob_entry = rob;
    disp_op        = op;
    disp_a_val     = a;
    disp_a_rdy     = ar;
    disp_a_tag     = at;
    disp_b_val     = b;
    disp_b_rdy     = br;
    disp_b_tag     = bt;
  endtask

  task automatic broadcast(input logic [3:0] tag, input logic [31:0] val);
    cdb_valid          = 1'b1;
    cdb.dest_ROB_entry = tag;
    cdb.result         = val;
  endtask

  task automatic expect_issue(input logic [3:0] rob, input ALU_op_t op,
                              input logic [31:0] a, input logic [31:0] b);
    exp_t e;
    e.rob = rob; e.op = op; e.a = a; e.b = b;
    sb_q.push_back(e);
  endtask

  // Monitor: one issue per cycle, sampled mid-cycle.
  always @(negedge clk) begin
    if (!reset && fu_valid) begin
      if (sb_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_issue: got rob=%0d a=0x%0h b=0x%0h, expected no issue",
                 fu_rob_entry, fu_a, fu_b);
      end else begin
        mon_e = sb_q.pop_front();
        check("issue_rob", 32'(fu_rob_entry), 32'(mon_e.rob));
        check("issue_op",  32'(fu_op),        32'(mon_e.op));
        check("issue_a",   fu_a,              mon_e.a);
        check("issue_b",   fu_b,              mon_e.b);
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  initial begin
    reset = 1'b1; flush = 1'b0; disp_valid = 1'b0; fu_ready = 1'b0;
    disp_rob_entry = '0; disp_op = ALU_MUL; disp_a_val = '0; disp_b_val = '0;
    disp_a_rdy = 1'b0; disp_b_rdy = 1'b0; disp_a_tag = '0; disp_b_tag = '0;
    cdb_valid = 1'b0; cdb = '0;

    #2;
    check("rst_disp_ready", 32'(disp_ready),   1);
    check("rst_fu_valid",   32'(fu_valid),     0);
    check("rst_fu_a",       fu_a,              0);
    check("rst_fu_b",       fu_b,              0);
    check("rst_fu_rob",     32'(fu_rob_entry), 0);
    check("rst_fu_op",      32'(fu_op),        0);
    check("rst_occupancy",  32'(occupancy),    0);
    cycle();
    reset = 1'b0;
    cycle();

    // Basic issue
    fu_ready = 1'b1;
    drive(4'd2, ALU_MUL, 32'd5, 1'b1, 4'd0, 32'd7, 1'b1, 4'd0);
    expect_issue(4'd2, ALU_MUL, 32'd5, 32'd7);
    #1;
    check("basic_no_same_cycle_issue", 32'(fu_valid), 0);
    cycle();
    disp_valid = 1'b0;
    check("basic_occ_1", 32'(occupancy), 1);
    cycle();
    check("basic_occ_0", 32'(occupancy), 0);

    // Operand wakeup
    drive(4'd3, ALU_MUL, 32'd0, 1'b0, 4'd9, 32'd4, 1'b1, 4'd0);
    cycle();
    disp_valid = 1'b0;
    check("wake_pending_no_issue", 32'(fu_valid), 0);
    check("wake_occ_1", 32'(occupancy), 1);
    cycle();
    check("wake_still_waiting", 32'(fu_valid), 0);
    broadcast(4'd9, 32'hFFFF_FFF6);
    expect_issue(4'd3, ALU_MUL, 32'hFFFF_FFF6, 32'd4);
    #1;
    check("wake_capture_cycle_no_issue", 32'(fu_valid), 0);
    cycle();
    cdb_valid = 1'b0;
    check("wake_issue_next_cycle", 32'(fu_valid), 1);
    cycle();
    check("wake_occ_0", 32'(occupancy), 0);

    // Dispatch-cycle capture
    drive(4'd6, ALU_MULH, 32'd11, 1'b1, 4'd0, 32'd0, 1'b0, 4'd5);
    broadcast(4'd5, 32'd3);
    expect_issue(4'd6, ALU_MULH, 32'd11, 32'd3);
    cycle();
    disp_valid = 1'b0;
    cdb_valid  = 1'b0;
    check("dcap_issue", 32'(fu_valid), 1);
    cycle();
    check("dcap_occ_0", 32'(occupancy), 0);

    // Full and backpressure
    fu_ready = 1'b0;
    for (int i = 0; i < 4; i++) begin
      drive(4'(8 + i), ALU_MUL, 32'(i + 1), 1'b1, 4'd0, 32'(100 + i), 1'b1, 4'd0);
      cycle();
    end
    disp_valid = 1'b0;
    check("full_disp_ready", 32'(disp_ready), 0);
    check("full_occ_4", 32'(occupancy), 4);
    check("full_no_issue_fu_busy", 32'(fu_valid), 0);
    drive(4'd12, ALU_MUL, 32'd99, 1'b1, 4'd0, 32'd99, 1'b1, 4'd0);
    cycle();
    disp_valid = 1'b0;
    check("full_5th_ignored", 32'(occupancy), 4);
    expect_issue(4'd8, ALU_MUL, 32'd1, 32'd100);
    fu_ready = 1'b1;
    cycle();
    fu_ready = 1'b0;
    check("bp_one_issue_occ_3", 32'(occupancy), 3);
    check("bp_disp_ready_back", 32'(disp_ready), 1);
    expect_issue(4'd9,  ALU_MUL, 32'd2, 32'd101);
    expect_issue(4'd10, ALU_MUL, 32'd3, 32'd102);
    expect_issue(4'd11, ALU_MUL, 32'd4, 32'd103);
    fu_ready = 1'b1;
    repeat (3) cycle();
    fu_ready = 1'b0;
    check("bp_drained_occ_0", 32'(occupancy), 0);

    // Ordering: A, B, C; free A; D lands in slot 0
    drive(4'd1, ALU_MUL, 32'd1, 1'b1, 4'd0, 32'd2, 1'b1, 4'd0);
    cycle();
    drive(4'd4, ALU_MUL, 32'd0, 1'b0, 4'd12, 32'd40, 1'b1, 4'd0);
    cycle();
    drive(4'd5, ALU_MUL, 32'd50, 1'b1, 4'd0, 32'd0, 1'b0, 4'd13);
    cycle();
    disp_valid = 1'b0;
    expect_issue(4'd1, ALU_MUL, 32'd1, 32'd2);
    fu_ready = 1'b1;
    cycle();
    fu_ready = 1'b0;
    check("ord_occ_2", 32'(occupancy), 2);
    drive(4'd7, ALU_MULH, 32'd0, 1'b0, 4'd12, 32'd70, 1'b1, 4'd0);
    cycle();
    disp_valid = 1'b0;
    check("ord_occ_3", 32'(occupancy), 3);
    broadcast(4'd12, 32'h0000_1234);
    cycle();
    broadcast(4'd13, 32'h0000_ABCD);
    cycle();
    cdb_valid = 1'b0;
`ifdef MUL_RS_AGE_EN
    expect_issue(4'd4, ALU_MUL,  32'h1234, 32'd40);
    expect_issue(4'd5, ALU_MUL,  32'd50,   32'hABCD);
    expect_issue(4'd7, ALU_MULH, 32'h1234, 32'd70);
`else
    expect_issue(4'd7, ALU_MULH, 32'h1234, 32'd70);
    expect_issue(4'd4, ALU_MUL,  32'h1234, 32'd40);
    expect_issue(4'd5, ALU_MUL,  32'd50,   32'hABCD);
`endif
    fu_ready = 1'b1;
    repeat (3) cycle();
    fu_ready = 1'b0;
    check("ord_occ_0", 32'(occupancy), 0);

    // Flush with simultaneous dispatch and pending issue
    drive(4'd2, ALU_MUL, 32'd3, 1'b1, 4'd0, 32'd4, 1'b1, 4'd0);
    cycle();
    disp_valid = 1'b0;
    check("flush_pre_occ_1", 32'(occupancy), 1);
    flush    = 1'b1;
    fu_ready = 1'b1;
    drive(4'd3, ALU_MUL, 32'd8, 1'b1, 4'd0, 32'd9, 1'b1, 4'd0);
    #1;
    check("flush_cycle_fu_valid", 32'(fu_valid), 0);
    cycle();
    flush      = 1'b0;
    disp_valid = 1'b0;
    fu_ready   = 1'b0;
    check("flush_occ_0", 32'(occupancy), 0);
    check("flush_after_fu_valid", 32'(fu_valid), 0);

    // Async reset mid-wakeup
    drive(4'd9, ALU_MUL, 32'd0, 1'b0, 4'd3, 32'd6, 1'b1, 4'd0);
    cycle();
    disp_valid = 1'b0;
    broadcast(4'd3, 32'h55);
    fu_ready = 1'b1;
    cycle();
    cdb_valid = 1'b0;
    check("areset_pre_fu_valid", 32'(fu_valid), 1);
    #1;
    reset = 1'b1;
    #1;
    check("areset_fu_valid",   32'(fu_valid),     0);
    check("areset_fu_a",       fu_a,              0);
    check("areset_fu_b",       fu_b,              0);
    check("areset_fu_rob",     32'(fu_rob_entry), 0);
    check("areset_occupancy",  32'(occupancy),    0);
    check("areset_disp_ready", 32'(disp_ready),   1);
    fu_ready = 1'b0;
    cycle();
    reset = 1'b0;
    repeat (4) cycle();

    check("scoreboard_empty", 32'(sb_q.size()), 0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
